board_move_engine: RTL and testbench

//  Owns the 8x8 checkers board state and sits directly upstream of the board drawer and cell-status lookup.

---
 rtl/checkers_pkg.sv | 51 +++++
 rtl/board_move_engine_if.sv | 28 ++
 rtl/board_cell_rd.sv | 12 +
 rtl/board_move_engine.sv | 162 ++++++++++++++++
 tb/tb_board_move_engine.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/checkers_pkg.sv
// Shared checkers types: cell codes, response codes, FSM states, board geometry and the standard start position.
package checkers_pkg;

    localparam int unsigned CELL_W  = 3;
    localparam int unsigned BOARD_W = 192;
    localparam int unsigned IDX_W   = 8;

    localparam logic [CELL_W-1:0] CELL_EMPTY   = 3'b000;
    localparam logic [CELL_W-1:0] CELL_P1_MAN  = 3'b001;
    localparam logic [CELL_W-1:0] CELL_P2_MAN  = 3'b010;
    localparam logic [CELL_W-1:0] CELL_P1_KING = 3'b101;
    localparam logic [CELL_W-1:0] CELL_P2_KING = 3'b110;

    typedef enum logic [1:0] {
        RSP_OK         = 2'b00,
        RSP_CAPTURE    = 2'b01,
        RSP_ILLEGAL    = 2'b10,
        RSP_WRONG_TURN = 2'b11
    } rsp_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_COMMIT,
        ST_RESP
    } state_e;

    // Bit offset of cell (x,y): 3*(8*y+x); {y,x} is 8*y+x.
    function automatic logic [IDX_W-1:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return IDX_W'({y, x}) * IDX_W'(CELL_W);
    endfunction

    // Men on dark squares ((x+y) odd): P1 on rows 0-2, P2 on rows 5-7.
    function automatic logic [BOARD_W-1:0] gen_std_start();
        logic [BOARD_W-1:0] b;
        b = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (((x + y) % 2) == 1) begin
                    if (y < 3)      b[cell_idx(3'(x), 3'(y)) +: CELL_W] = CELL_P1_MAN;
                    else if (y > 4) b[cell_idx(3'(x), 3'(y)) +: CELL_W] = CELL_P2_MAN;
                end
            end
        end
        return b;
    endfunction

    localparam logic [BOARD_W-1:0] STD_START = gen_std_start();

endpackage

// File: rtl/board_move_engine_if.sv
// Command/response/board bus between a move-command source and board_move_engine.
interface board_move_engine_if;
    import checkers_pkg::*;

    logic               new_game;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_player;
    logic [2:0]         cmd_src_x;
    logic [2:0]         cmd_src_y;
    logic [2:0]         cmd_dst_x;
    logic [2:0]         cmd_dst_y;
    logic               rsp_valid;
    logic [1:0]         rsp_code;
    logic [BOARD_W-1:0] board_out;
    logic               turn;
    logic               board_changed;

    modport slave (
        input  new_game, cmd_valid, cmd_player, cmd_src_x, cmd_src_y, cmd_dst_x, cmd_dst_y,
        output cmd_ready, rsp_valid, rsp_code, board_out, turn, board_changed
    );

    modport master (
        output new_game, cmd_valid, cmd_player, cmd_src_x, cmd_src_y, cmd_dst_x, cmd_dst_y,
        input  cmd_ready, rsp_valid, rsp_code, board_out, turn, board_changed
    );
endinterface

// File: rtl/board_cell_rd.sv
// Combinational 3-bit cell read at (x,y) from the packed board vector.
module board_cell_rd
    import checkers_pkg::*;
(
    input  logic [BOARD_W-1:0] board_i,
    input  logic [2:0]         x_i,
    input  logic [2:0]         y_i,
    output logic [CELL_W-1:0]  cell_c_o
);
    // Pure mux; the caller registers the result.
    assign cell_c_o = board_i[cell_idx(x_i, y_i) +: CELL_W];
endmodule

// File: rtl/board_move_engine.sv
// Checkers board owner: validates one move at a time and commits legal moves.
// Optional feature macro KING_PROMOTE_EN: men reaching the far row are crowned during commit.
module board_move_engine
    import checkers_pkg::*;
#(
    parameter logic [BOARD_W-1:0] INIT_BOARD = STD_START
) (
    input  logic               clk,
    input  logic               rst,
    board_move_engine_if.slave bus
);

    state_e             state_q;
    logic [BOARD_W-1:0] board_q, board_d;
    logic               turn_q;
    logic               player_q;
    logic [2:0]         src_x_q, src_y_q, dst_x_q, dst_y_q;
    logic [CELL_W-1:0]  src_cell_q, dst_cell_q, mid_cell_q;
    rsp_code_e          code_q, code_d;
    logic               rsp_valid_q;
    rsp_code_e          rsp_code_q;
    logic               board_changed_q;

    logic [CELL_W-1:0]  src_rd_c, dst_rd_c, mid_rd_c, land_cell_c;
    logic signed [3:0]  dx_c, dy_c;
    logic [3:0]         adx_c, ady_c;
    logic [2:0]         mid_x_c, mid_y_c;
    logic               src_own_c, src_king_c, mid_opp_c, step_fwd_c, jump_fwd_c;

    // Signed deltas and jump midpoint; the midpoint only matters when |dx|=|dy|=2.
    assign dx_c    = $signed({1'b0, dst_x_q}) - $signed({1'b0, src_x_q});
    assign dy_c    = $signed({1'b0, dst_y_q}) - $signed({1'b0, src_y_q});
    assign adx_c   = dx_c[3] ? 4'(-dx_c) : 4'(dx_c);
    assign ady_c   = dy_c[3] ? 4'(-dy_c) : 4'(dy_c);
    assign mid_x_c = src_x_q + 3'(dx_c >>> 1);
    assign mid_y_c = src_y_q + 3'(dy_c >>> 1);

    board_cell_rd u_rd_src (.board_i(board_q), .x_i(src_x_q), .y_i(src_y_q), .cell_c_o(src_rd_c));
    board_cell_rd u_rd_dst (.board_i(board_q), .x_i(dst_x_q), .y_i(dst_y_q), .cell_c_o(dst_rd_c));
    board_cell_rd u_rd_mid (.board_i(board_q), .x_i(mid_x_c), .y_i(mid_y_c), .cell_c_o(mid_rd_c));

    // Ownership and direction terms from the fetched cells.
    assign src_own_c  = player_q ? (src_cell_q == CELL_P2_MAN || src_cell_q == CELL_P2_KING)
                                 : (src_cell_q == CELL_P1_MAN || src_cell_q == CELL_P1_KING);
    assign src_king_c = (src_cell_q == CELL_P1_KING) || (src_cell_q == CELL_P2_KING);
    assign mid_opp_c  = player_q ? (mid_cell_q == CELL_P1_MAN || mid_cell_q == CELL_P1_KING)
                                 : (mid_cell_q == CELL_P2_MAN || mid_cell_q == CELL_P2_KING);
    assign step_fwd_c = player_q ? (dy_c == -4'sd1) : (dy_c == 4'sd1);
    assign jump_fwd_c = player_q ? (dy_c == -4'sd2) : (dy_c == 4'sd2);

    // Legality in priority order: turn, ownership/occupancy, step, jump, otherwise illegal.
    always_comb begin
        code_d = RSP_ILLEGAL;
        if (player_q != turn_q) begin
            code_d = RSP_WRONG_TURN;
        end else if (!src_own_c || dst_cell_q != CELL_EMPTY) begin
            code_d = RSP_ILLEGAL;
        end else if (adx_c == 4'd1 && ady_c == 4'd1 && (src_king_c || step_fwd_c)) begin
            code_d = RSP_OK;
        end else if (adx_c == 4'd2 && ady_c == 4'd2 && mid_opp_c && (src_king_c || jump_fwd_c)) begin
            code_d = RSP_CAPTURE;
        end
    end

    // Code of the piece as it lands on the destination.
    always_comb begin
        land_cell_c = src_cell_q;
`ifdef KING_PROMOTE_EN
        if (src_cell_q == CELL_P1_MAN && dst_y_q == 3'd7) begin
            land_cell_c = CELL_P1_KING;
        end else if (src_cell_q == CELL_P2_MAN && dst_y_q == 3'd0) begin
            land_cell_c = CELL_P2_KING;
        end
`endif
    end

    // Board image after a legal move; the destination is written last.
    always_comb begin
        board_d = board_q;
        board_d[cell_idx(src_x_q, src_y_q) +: CELL_W] = CELL_EMPTY;
        if (code_q == RSP_CAPTURE) begin
            board_d[cell_idx(mid_x_c, mid_y_c) +: CELL_W] = CELL_EMPTY;
        end
        board_d[cell_idx(dst_x_q, dst_y_q) +: CELL_W] = land_cell_c;
    end

    // Move FSM with registered outputs; new_game overrides any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            board_q         <= INIT_BOARD;
            turn_q          <= 1'b0;
            player_q        <= 1'b0;
            src_x_q         <= '0;
            src_y_q         <= '0;
            dst_x_q         <= '0;
            dst_y_q         <= '0;
            src_cell_q      <= CELL_EMPTY;
            dst_cell_q      <= CELL_EMPTY;
            mid_cell_q      <= CELL_EMPTY;
            code_q          <= RSP_OK;
            rsp_valid_q     <= 1'b0;
            rsp_code_q      <= RSP_OK;
            board_changed_q <= 1'b0;
        end else if (bus.new_game) begin
            state_q         <= ST_IDLE;
            board_q         <= INIT_BOARD;
            turn_q          <= 1'b0;
            rsp_valid_q     <= 1'b0;
            board_changed_q <= 1'b1;
        end else begin
            rsp_valid_q     <= 1'b0;
            board_changed_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        player_q <= bus.cmd_player;
                        src_x_q  <= bus.cmd_src_x;
                        src_y_q  <= bus.cmd_src_y;
                        dst_x_q  <= bus.cmd_dst_x;
                        dst_y_q  <= bus.cmd_dst_y;
                        state_q  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    src_cell_q <= src_rd_c;
                    dst_cell_q <= dst_rd_c;
                    mid_cell_q <= mid_rd_c;
                    state_q    <= ST_CHECK;
                end
                ST_CHECK: begin
                    code_q  <= code_d;
                    state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (code_q == RSP_OK || code_q == RSP_CAPTURE) begin
                        board_q         <= board_d;
                        turn_q          <= ~turn_q;
                        board_changed_q <= 1'b1;
                    end
                    rsp_valid_q <= 1'b1;
                    rsp_code_q  <= code_q;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready     = (state_q == ST_IDLE) && !bus.new_game;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_code      = rsp_code_q;
    assign bus.board_out     = board_q;
    assign bus.turn          = turn_q;
    assign bus.board_changed = board_changed_q;

endmodule

// File: tb/tb_board_move_engine.sv
// Scoreboard bench for board_move_engine: DUT A starts from the standard board, DUT B from a sparse custom board.
module tb_board_move_engine;
    import checkers_pkg::*;

    localparam int unsigned BW = 192;

    typedef struct {
        logic [1:0]    code;
        logic [BW-1:0] board;
        logic          turn;
        logic          bc;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bc_cnt[2];
    exp_t q0[$];
    exp_t q1[$];

    logic          ng[2], cv[2], cp[2];
    logic [2:0]    sx[2], sy[2], tx[2], ty[2];
    logic [BW-1:0] mb[2];
    logic          mt[2];

    board_move_engine_if ia();
    board_move_engine_if ib();

    assign ia.new_game   = ng[0];
    assign ia.cmd_valid  = cv[0];
    assign ia.cmd_player = cp[0];
    assign ia.cmd_src_x  = sx[0];
    assign ia.cmd_src_y  = sy[0];
    assign ia.cmd_dst_x  = tx[0];
    assign ia.cmd_dst_y  = ty[0];
    assign ib.new_game   = ng[1];
    assign ib.cmd_valid  = cv[1];
    assign ib.cmd_player = cp[1];
    assign ib.cmd_src_x  = sx[1];
    assign ib.cmd_src_y  = sy[1];
    assign ib.cmd_dst_x  = tx[1];
    assign ib.cmd_dst_y  = ty[1];

    // Bench-side board helpers, independent of the RTL package functions.
    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int x, input int y, input logic [2:0] c);
        logic [BW-1:0] r;
        r = b;
        r[3*(8*y+x) +: 3] = c;
        return r;
    endfunction

    function automatic logic [2:0] getc(input logic [BW-1:0] b, input int x, input int y);
        return b[3*(8*y+x) +: 3];
    endfunction

    function automatic logic [BW-1:0] std_board();
        logic [BW-1:0] b;
        b = '0;
        for (int y = 0; y < 8; y++) begin
            for (int k = 0; k < 4; k++) begin
                if (y <= 2) b = put(b, 2*k + ((y % 2 == 0) ? 1 : 0), y, 3'b001);
                if (y >= 5) b = put(b, 2*k + ((y % 2 == 0) ? 1 : 0), y, 3'b010);
            end
        end
        return b;
    endfunction

    function automatic logic [BW-1:0] b_board();
        logic [BW-1:0] b;
        b = '0;
        b = put(b, 2, 2, 3'b001);
        b = put(b, 3, 3, 3'b010);
        b = put(b, 1, 6, 3'b001);
        b = put(b, 6, 1, 3'b110);
        return b;
    endfunction

    localparam logic [BW-1:0] B_INIT = b_board();

    logic [BW-1:0] std_b;
    initial std_b = std_board();

    board_move_engine #(.INIT_BOARD(STD_START)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    board_move_engine #(.INIT_BOARD(B_INIT))    dut_b (.clk(clk), .rst(rst), .bus(ib));

    function automatic logic rdy(input int u);
        return (u == 0) ? ia.cmd_ready : ib.cmd_ready;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop and compare on every response pulse, count board_changed pulses.
    task automatic check_rsp(input int u);
        exp_t e;
        logic [1:0] code;
        logic [BW-1:0] brd;
        logic trn, bc;
        code = (u == 0) ? ia.rsp_code : ib.rsp_code;
        brd  = (u == 0) ? ia.board_out : ib.board_out;
        trn  = (u == 0) ? ia.turn : ib.turn;
        bc   = (u == 0) ? ia.board_changed : ib.board_changed;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 code=%b expected no response", u, code);
            return;
        end
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp_code dut%0d", u), BW'(code), BW'(e.code));
        chk($sformatf("board dut%0d", u), brd, e.board);
        chk($sformatf("turn dut%0d", u), BW'(trn), BW'(e.turn));
        chk($sformatf("board_changed_at_rsp dut%0d", u), BW'(bc), BW'(e.bc));
        chk($sformatf("latency dut%0d", u), BW'(cyc - e.acc), BW'(4));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ia.rsp_valid) check_rsp(0);
            if (ib.rsp_valid) check_rsp(1);
            if (ia.board_changed) bc_cnt[0]++;
            if (ib.board_changed) bc_cnt[1]++;
        end
    end

    // Acceptance with fields already on the bus: push expectation, hold until the accepting edge.
    task automatic accept_now(input int u, input logic [1:0] code, input logic [2:0] land);
        exp_t e;
        int n;
        logic legal;
        n = 0;
        while (!rdy(u) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(u)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: cmd_ready=0 expected 1 within 100 cycles", u);
            cv[u] = 1'b0;
            return;
        end
        legal = (code == 2'b00) || (code == 2'b01);
        if (legal) begin
            mb[u] = put(mb[u], sx[u], sy[u], 3'b000);
            if (code == 2'b01) mb[u] = put(mb[u], (int'(sx[u]) + int'(tx[u])) / 2, (int'(sy[u]) + int'(ty[u])) / 2, 3'b000);
            mb[u] = put(mb[u], tx[u], ty[u], land);
            mt[u] = ~mt[u];
        end
        e = '{code: code, board: mb[u], turn: mt[u], bc: legal, acc: cyc};
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1 cv[u] = 1'b0;
    endtask

    task automatic issue(input int u, input logic p, input int x0, input int y0, input int x1, input int y1,
                         input logic [1:0] code, input logic [2:0] land);
        @(negedge clk);
        cp[u] = p;
        sx[u] = 3'(x0);
        sy[u] = 3'(y0);
        tx[u] = 3'(x1);
        ty[u] = 3'(y1);
        cv[u] = 1'b1;
        #1;
        accept_now(u, code, land);
    endtask

    task automatic wait_done(input int u);
        int n;
        n = 0;
        while (((u == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (((u == 0) ? q0.size() : q1.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout dut%0d: no response within 50 cycles", u);
            if (u == 0) q0.delete(); else q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc0;
        logic [2:0] promo;
        for (int i = 0; i < 2; i++) begin
            ng[i] = 1'b0; cv[i] = 1'b0; cp[i] = 1'b0;
            sx[i] = '0; sy[i] = '0; tx[i] = '0; ty[i] = '0;
            mt[i] = 1'b0; bc_cnt[i] = 0;
        end
        mb[0] = std_board();
        mb[1] = b_board();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        chk("rst_board_a", ia.board_out, std_b);
        chk("rst_turn_a", BW'(ia.turn), BW'(0));
        chk("rst_cmd_ready_a", BW'(ia.cmd_ready), BW'(1));
        chk("rst_rsp_valid_a", BW'(ia.rsp_valid), BW'(0));
        chk("rst_rsp_code_a", BW'(ia.rsp_code), BW'(0));
        chk("rst_board_changed_a", BW'(ia.board_changed), BW'(0));
        chk("rst_board_b", ib.board_out, B_INIT);
        chk("rst_no_bc_pulse", BW'(bc_cnt[0] + bc_cnt[1]), BW'(0));

        // Simple step, then a P2 reply, then out-of-turn and illegal shapes.
        bc0 = bc_cnt[0];
        issue(0, 1'b0, 1, 2, 0, 3, 2'b00, 3'b001);
        wait_done(0);
        chk("cell_0_3", BW'(getc(ia.board_out, 0, 3)), BW'(3'b001));
        chk("cell_1_2", BW'(getc(ia.board_out, 1, 2)), BW'(3'b000));
        chk("bc_once_move1", BW'(bc_cnt[0] - bc0), BW'(1));
        issue(0, 1'b1, 0, 5, 1, 4, 2'b00, 3'b010);
        issue(0, 1'b1, 2, 5, 3, 4, 2'b11, 3'b000);
        issue(0, 1'b0, 3, 2, 3, 3, 2'b10, 3'b000);
        issue(0, 1'b0, 0, 3, 1, 2, 2'b10, 3'b000);
        issue(0, 1'b0, 3, 2, 3, 2, 2'b10, 3'b000);
        wait_done(0);

        // Capture, king backward step, and far-row landing on the custom board.
`ifdef KING_PROMOTE_EN
        promo = 3'b101;
`else
        promo = 3'b001;
`endif
        issue(1, 1'b0, 2, 2, 0, 4, 2'b10, 3'b000);
        issue(1, 1'b0, 2, 2, 4, 4, 2'b01, 3'b001);
        issue(1, 1'b1, 6, 1, 7, 2, 2'b00, 3'b110);
        issue(1, 1'b0, 1, 6, 0, 7, 2'b00, promo);
        wait_done(1);
        chk("capture_mid_3_3", BW'(getc(ib.board_out, 3, 3)), BW'(3'b000));
        chk("promote_cell_0_7", BW'(getc(ib.board_out, 0, 7)), BW'(promo));

        // new_game one cycle after acceptance: no response, board reloaded, one pulse.
        bc0 = bc_cnt[0];
        @(negedge clk);
        cp[0] = 1'b0; sx[0] = 3'd5; sy[0] = 3'd2; tx[0] = 3'd4; ty[0] = 3'd3;
        cv[0] = 1'b1;
        @(posedge clk);
        #1 cv[0] = 1'b0; ng[0] = 1'b1;
        @(posedge clk);
        #1 ng[0] = 1'b0;
        repeat (8) @(negedge clk);
        mb[0] = std_board();
        mt[0] = 1'b0;
        chk("new_game_board", ia.board_out, std_b);
        chk("new_game_turn", BW'(ia.turn), BW'(0));
        chk("new_game_bc_once", BW'(bc_cnt[0] - bc0), BW'(1));

        // Held command during new_game is only taken once new_game drops.
        @(negedge clk);
        ng[0] = 1'b1;
        cv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ready_low_in_new_game", BW'(ia.cmd_ready), BW'(0));
        end
        ng[0] = 1'b0;
        #1;
        accept_now(0, 2'b00, 3'b001);
        wait_done(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
